// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding and memory-control constants for mem_stage
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int MEM_R_BIT         = 1;
   localparam int MEM_W_BIT         = 0;
   localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble load
module mem_wb_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble,
   input  logic        wb_en_d,
   input  logic        mem_r_en_d,
   input  logic [4:0]  dest_d,
   input  logic [31:0] alu_d,
   input  logic [31:0] data_d,
   output logic        wb_en_q,
   output logic        mem_r_en_q,
   output logic [4:0]  dest_q,
   output logic [31:0] alu_q,
   output logic [31:0] data_q
);

   // A bubble only needs to kill the two enables; the payload is don't-care downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         dest_q     <= 5'd0;
         alu_q      <= 32'd0;
         data_q     <= 32'd0;
      end else begin
         wb_en_q    <= wb_en_d & ~bubble;
         mem_r_en_q <= mem_r_en_d & ~bubble;
         dest_q     <= dest_d;
         alu_q      <= alu_d;
         data_q     <= data_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with req/ack data-memory handshake
// Optional access watchdog and sticky mem_err port enabled by MEM_TIMEOUT_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int ADDR_W    = 8
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 15
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_en_in,
   input  logic [1:0]        MEM_Signal_in,
   input  logic [4:0]        dest_in,
   input  logic [31:0]       ALU_result_in,
   input  logic [31:0]       reg2_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              freeze,
   output logic              WB_en_out,
   output logic              MEM_R_en_out,
   output logic [4:0]        dest_out,
   output logic [31:0]       ALU_result_out,
   output logic [31:0]       mem_data_out
`ifdef MEM_TIMEOUT_EN
   , output logic            mem_err
`endif
);

   state_t state, state_nxt;

   logic              is_mem;
   logic              timeout;
   logic              freeze_c;
   logic              bubble;
   logic              wb_d, mr_d;
   logic [4:0]        dest_d;
   logic [31:0]       alu_d, data_d;
   logic [ADDR_W-1:0] addr_d;

   logic              req_q, we_q, wb_q, mr_q;
   logic [4:0]        dest_q;
   logic [31:0]       alu_q, wdata_q, rdata_q;
   logic [ADDR_W-1:0] addr_q;

   assign is_mem = |MEM_Signal_in;
   // Offset from the base, drop byte lanes, and let the cast wrap into the memory depth.
   assign addr_d = ADDR_W'((ALU_result_in - 32'(BASE_ADDR)) >> 2);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   assign timeout = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
         if (timeout) mem_err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      freeze_c  = 1'b0;
      bubble    = 1'b0;
      wb_d      = WB_en_in;
      mr_d      = 1'b0;
      dest_d    = dest_in;
      alu_d     = ALU_result_in;
      data_d    = 32'd0;
      case (state)
         IDLE: begin
            if (is_mem) begin
               freeze_c  = 1'b1;
               bubble    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            freeze_c = 1'b1;
            bubble   = 1'b1;
            if (mem_ack || timeout) state_nxt = DONE;
         end
         DONE: begin
            wb_d      = wb_q;
            mr_d      = mr_q;
            dest_d    = dest_q;
            alu_d     = alu_q;
            data_d    = mr_q ? rdata_q : 32'd0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operation is latched on entry so upstream contents are irrelevant until DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         wb_q    <= 1'b0;
         mr_q    <= 1'b0;
         dest_q  <= 5'd0;
         alu_q   <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         addr_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_mem) begin
                  req_q   <= 1'b1;
                  we_q    <= MEM_Signal_in[MEM_W_BIT] & ~MEM_Signal_in[MEM_R_BIT];
                  wb_q    <= WB_en_in;
                  mr_q    <= MEM_Signal_in[MEM_R_BIT];
                  dest_q  <= dest_in;
                  alu_q   <= ALU_result_in;
                  wdata_q <= reg2_in;
                  addr_q  <= addr_d;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  req_q   <= 1'b0;
                  rdata_q <= mem_rdata;
               end else if (timeout) begin
                  req_q   <= 1'b0;
                  rdata_q <= 32'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = req_q & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign freeze    = freeze_c & rst;

   mem_wb_reg u_mem_wb_reg (
      .clk        (clk),
      .rst        (rst),
      .bubble     (bubble),
      .wb_en_d    (wb_d),
      .mem_r_en_d (mr_d),
      .dest_d     (dest_d),
      .alu_d      (alu_d),
      .data_d     (data_d),
      .wb_en_q    (WB_en_out),
      .mem_r_en_q (MEM_R_en_out),
      .dest_q     (dest_out),
      .alu_q      (ALU_result_out),
      .data_q     (mem_data_out)
   );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              WB_en_in;
   logic [1:0]        MEM_Signal_in;
   logic [4:0]        dest_in;
   logic [31:0]       ALU_result_in;
   logic [31:0]       reg2_in;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;
   logic              freeze;
   logic              WB_en_out;
   logic              MEM_R_en_out;
   logic [4:0]        dest_out;
   logic [31:0]       ALU_result_out;
   logic [31:0]       mem_data_out;
`ifdef MEM_TIMEOUT_EN
   logic              mem_err;
`endif

   typedef struct packed {
      logic        wb;
      logic        mr;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   mem_stage #(.BASE_ADDR(1024), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .WB_en_in       (WB_en_in),
      .MEM_Signal_in  (MEM_Signal_in),
      .dest_in        (dest_in),
      .ALU_result_in  (ALU_result_in),
      .reg2_in        (reg2_in),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .freeze         (freeze),
      .WB_en_out      (WB_en_out),
      .MEM_R_en_out   (MEM_R_en_out),
      .dest_out       (dest_out),
      .ALU_result_out (ALU_result_out),
      .mem_data_out   (mem_data_out)
`ifdef MEM_TIMEOUT_EN
      , .mem_err      (mem_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] sig, input logic wb, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] wd);
      MEM_Signal_in = sig;
      WB_en_in      = wb;
      dest_in       = dest;
      ALU_result_in = alu;
      reg2_in       = wd;
   endtask

   task automatic cmp_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_wb"},   {31'd0, WB_en_out},    {31'd0, e.wb});
         chk({tag, "_mr"},   {31'd0, MEM_R_en_out}, {31'd0, e.mr});
         chk({tag, "_dest"}, {27'd0, dest_out},     {27'd0, e.dest});
         chk({tag, "_alu"},  ALU_result_out,        e.alu);
         chk({tag, "_data"}, mem_data_out,          e.data);
      end
   endtask

   // Called at a negedge; returns at the next negedge with the result checked.
   task automatic nop_op(input string tag, input logic wb, input logic [4:0] dest,
                         input logic [31:0] alu);
      drive(2'b00, wb, dest, alu, $urandom);
      sb.push_back('{wb, 1'b0, dest, alu, 32'd0});
      #1 chk({tag, "_freeze"}, {31'd0, freeze}, 32'd0);
      @(negedge clk);
      chk({tag, "_freeze_after"}, {31'd0, freeze}, 32'd0);
      cmp_out(tag);
   endtask

   // Memory op acked k cycles after mem_req rises; result checked k+2 cycles after entry.
   task automatic mem_op(input string tag, input logic [1:0] sig, input logic wb,
                         input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] wd,
                         input int k, input logic [31:0] rd, input logic [ADDR_W-1:0] exp_addr);
      int fc = 0;
      drive(sig, wb, dest, alu, wd);
      sb.push_back('{wb, sig[1], dest, alu, (sig[1] ? rd : 32'd0)});
      for (int c = 0; c <= k + 1; c++) begin
         #1;
         if (freeze) fc++;
         if (c == 0) chk({tag, "_req_c0"}, {31'd0, mem_req}, 32'd0);
         if (c == 1) begin
            chk({tag, "_req"},   {31'd0, mem_req}, 32'd1);
            chk({tag, "_addr"},  {24'd0, mem_addr}, {24'd0, exp_addr});
            chk({tag, "_we"},    {31'd0, mem_we}, {31'd0, (sig == 2'b01)});
            if (sig == 2'b01) chk({tag, "_wdata"}, mem_wdata, wd);
         end
         mem_ack   = (c == k);
         mem_rdata = (c == k) ? rd : $urandom;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk({tag, "_freeze_cycles"}, fc, k + 1);
      drive(2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
      #1 chk({tag, "_req_dropped"}, {31'd0, mem_req}, 32'd0);
      cmp_out(tag);
   endtask

   initial begin
      rst       = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      drive(2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_freeze", {31'd0, freeze}, 32'd0);
      chk("rst_req",    {31'd0, mem_req}, 32'd0);
      chk("rst_bus",    {mem_we, 23'd0, mem_addr}, 32'd0);
      chk("rst_wdata",  mem_wdata, 32'd0);
      chk("rst_mwb",    {WB_en_out, MEM_R_en_out, 25'd0, dest_out}, 32'd0);
      chk("rst_alu",    ALU_result_out | mem_data_out, 32'd0);
      rst = 1'b1;

      nop_op("add", 1'b1, 5'd5, 32'h12);
      nop_op("add2", 1'b1, 5'd9, 32'hFFFF_0001);

      mem_op("store", 2'b01, 1'b0, 5'd0, 32'd1032, 32'hDEAD_BEEF, 3, 32'h0, 8'd2);
      mem_op("load",  2'b10, 1'b1, 5'd7, 32'd1032, 32'h0, 1, 32'hDEAD_BEEF, 8'd2);
      mem_op("load_b2b", 2'b10, 1'b1, 5'd3, 32'd1059, 32'h0, 2, 32'h1234_5678, 8'd8);
      mem_op("rw_wrap", 2'b11, 1'b1, 5'd4, 32'd2048, 32'h5555_AAAA, 2, 32'hCAFE_F00D, 8'd0);

      // Reset in the middle of an access.
      drive(2'b10, 1'b1, 5'd6, 32'd1040, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rstacc_req_before", {31'd0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rstacc_req",    {31'd0, mem_req}, 32'd0);
      chk("rstacc_freeze", {31'd0, freeze}, 32'd0);
      drive(2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      rst       = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("spur_req",    {31'd0, mem_req}, 32'd0);
      chk("spur_freeze", {31'd0, freeze}, 32'd0);
      chk("spur_mwb",    {WB_en_out, MEM_R_en_out, 30'd0}, 32'd0);
      @(negedge clk);
      nop_op("post_rst", 1'b1, 5'd1, 32'h77);

`ifdef MEM_TIMEOUT_EN
      begin
         int fc = 0;
         int c  = 0;
         drive(2'b10, 1'b1, 5'd2, 32'd1044, 32'd0);
         sb.push_back('{1'b1, 1'b1, 5'd2, 32'd1044, 32'd0});
         mem_rdata = 32'hFFFF_FFFF;
         while (c < 40) begin
            #1;
            if (!freeze && c > 0) break;
            if (freeze) fc++;
            c++;
            @(negedge clk);
         end
         chk("to_freeze_cycles", fc, 16);
         chk("to_err", {31'd0, mem_err}, 32'd1);
         drive(2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
         @(negedge clk);
         cmp_out("to");
         chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
      end
`endif

      chk("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It consumes the EXE/MEM pipeline register (write-back enable, memory-control pair, destination, ALU result, store data) and performs loads and stores on a word-wide external data memory through a request/acknowledge handshake. It freezes the upstream pipeline while an access is outstanding and drives the MEM/WB pipeline register toward write-back.

## Interface
- BASE_ADDR, 1024: byte address mapped to memory word 0.
- ADDR_W, 8: word-address width; memory depth is 2^ADDR_W words.
- TIMEOUT_CYCLES, 15: watchdog limit, used only when MEM_TIMEOUT_EN is defined.

- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- WB_en_in  input  1  write-back enable from the EXE/MEM register.
- MEM_Signal_in  input  2  [1] = memory read, [0] = memory write.
- dest_in  input  5  destination register.
- ALU_result_in  input  32  effective byte address, or the result for non-memory operations.
- reg2_in  input  32  store data.
- mem_req  output  1  access request to data memory.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  load data; valid in the cycle mem_ack is high.
- mem_ack  input  1  one-cycle completion pulse.
- freeze  output  1  stall for the PC, IF/ID, ID/EXE and EXE/MEM registers.
- WB_en_out, MEM_R_en_out  output  1 each  to the MEM/WB register.
- dest_out  output  5  to the MEM/WB register.
- ALU_result_out, mem_data_out  output  32 each  to the MEM/WB register.
- mem_err  output  1  sticky timeout flag; present only when MEM_TIMEOUT_EN is defined.

## Operation
- Word address: mem_addr = (ALU_result_in − BASE_ADDR) >> 2, truncated to ADDR_W bits.
  - Addresses wrap modulo the memory depth.
  - Byte-offset bits [1:0] are ignored.
- MEM_Signal_in = 2'b11: treated as a read; the write is suppressed.
- States are IDLE, ACCESS and DONE.
  - IDLE with MEM_Signal_in = 0: no access. The MEM/WB register loads the inputs, and mem_data_out is loaded with 0.
  - IDLE with MEM_Signal_in ≠ 0: freeze rises combinationally in the same cycle. The MEM/WB register loads a bubble (WB_en_out = 0, MEM_R_en_out = 0). Next state is ACCESS.
  - ACCESS: mem_req, mem_we, mem_addr and mem_wdata are driven from registers and held stable until mem_ack. freeze = 1 and a bubble is loaded each cycle. On mem_ack, mem_rdata is captured and the next state is DONE.
  - DONE: freeze = 0. The MEM/WB register loads the held inputs plus the captured data; for a store, mem_data_out = 0. Next state is IDLE unconditionally.
- freeze = (IDLE and MEM_Signal_in ≠ 0) or ACCESS.
- mem_ack outside ACCESS is ignored.
- The EXE/MEM register holds its contents while freeze = 1; this is upstream's responsibility.

## Timing
- Reset: every output is 0 and the state is IDLE.
  - All MEM/WB outputs, mem_req, mem_we, mem_addr, mem_wdata, freeze and mem_err are 0.
  - Assertion takes effect immediately; a reset during ACCESS drops mem_req without waiting for mem_ack.
- Non-memory operation: 1-cycle latency, no stall.
- Memory operation acknowledged k cycles after mem_req rises (k ≥ 1):
  - freeze is high for k+1 cycles.
  - The result appears on the MEM/WB outputs k+2 cycles after the operation entered.
- mem_req rises one cycle after the operation is first presented. It falls on the edge after mem_ack.
- Back-to-back memory operations each pass through DONE, so there is one non-frozen cycle between accesses.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A cycle counter runs in ACCESS and clears in every other state.
  - If it reaches TIMEOUT_CYCLES with no mem_ack, the access is abandoned: next state is DONE, captured data = 32'h0, and mem_err is set.
  - mem_err stays set until reset.
- MEM_TIMEOUT_EN undefined: no counter and no mem_err port; ACCESS waits for mem_ack indefinitely.

## Structure
- Shared package:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - MEM_Signal bit indices (MEM_R_BIT = 1, MEM_W_BIT = 0);
  - the default BASE_ADDR.
- One sub-module, mem_wb_reg: the MEM/WB pipeline register with asynchronous active-low reset and a bubble-load input.

## Test plan
- ADD result 32'h12 to dest 5, MEM_Signal_in = 0 → next cycle WB_en_out = 1, dest_out = 5, ALU_result_out = 32'h12; freeze never rises.
- Store reg2_in = 32'hDEAD_BEEF to address 1032, ack 3 cycles after mem_req → mem_addr = 2, mem_we = 1; freeze high for 4 cycles; then WB_en_out = 0 and MEM_R_en_out = 0.
- Load from 1032 with mem_rdata = 32'hDEAD_BEEF, ack after 1 cycle → mem_data_out = 32'hDEAD_BEEF, MEM_R_en_out = 1, 3 cycles after entry.
- Reset asserted in ACCESS → mem_req and freeze drop immediately; after release the state is IDLE and a spurious mem_ack is ignored.
- MEM_Signal_in = 2'b11 with address 1024 + 4·256 → read of word 0 (wrap); mem_we stays 0.
- With MEM_TIMEOUT_EN and no ack → exit after 15 cycles; mem_err = 1 and mem_data_out = 0.
